alu8_arbiter: RTL

ALU8_ARBITER -- requirements
Module: alu8_arbiter

---
 rtl/alu8_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu8_arbiter.sv
// Two-requester front end for a shared 8-bit adder: round-robin arbitration, operand issue, response return.
// Define ALU8_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 wins contention).
module alu8_arbiter #(
    parameter int ALU_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req0_op1,
    input  logic [7:0] req0_op2,
    input  logic [7:0] req1_op1,
    input  logic [7:0] req1_op2,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic       alu_start,
    input  logic [7:0] alu_sum,
    input  logic [3:0] alu_flags,
    output logic [1:0] resp_valid,
    input  logic [1:0] resp_ready,
    output logic [7:0] resp_sum,
    output logic [3:0] resp_flags,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_ISSUE = 4'(ALU_LAT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       win_q, win_d;
    logic [7:0] alu_op1_q, alu_op1_d;
    logic [7:0] alu_op2_q, alu_op2_d;
    logic       alu_start_q, alu_start_d;
    logic [1:0] resp_valid_q, resp_valid_d;
    logic [7:0] resp_sum_q, resp_sum_d;
    logic [3:0] resp_flags_q, resp_flags_d;

    logic       accept;
    logic       gnt_idx;
    logic [1:0] gnt_oh;

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high.
    // Requesters may drop valid at any time before ready; responses hold until the winner's ready.
    assign accept = (state_q == IDLE) && (req_valid != 2'b00);

`ifdef ALU8_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_idx = ~req_valid[0];
    end
`else
    logic last_q, last_d;

    always_comb begin
        if (req_valid == 2'b11) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = req_valid[1];
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt_idx;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt_oh = gnt_idx ? 2'b10 : 2'b01;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_start_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_flags_d = resp_flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    win_d       = gnt_idx;
                    alu_op1_d   = gnt_idx ? req1_op1 : req0_op1;
                    alu_op2_d   = gnt_idx ? req1_op2 : req0_op2;
                    alu_start_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_ISSUE) begin
                    resp_sum_d   = alu_sum;
                    resp_flags_d = alu_flags;
                    resp_valid_d = win_q ? 2'b10 : 2'b01;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready[win_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            win_q        <= 1'b0;
            alu_op1_q    <= 8'd0;
            alu_op2_q    <= 8'd0;
            alu_start_q  <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_sum_q   <= 8'd0;
            resp_flags_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_start_q  <= alu_start_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    // Ready is combinational from valid, so it is gated by rst_n to drop the instant reset asserts.
    assign req_ready  = (accept && rst_n) ? gnt_oh : 2'b00;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_start  = alu_start_q;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_flags = resp_flags_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule
